note_sequencer: RTL and testbench

- Upstream stage of note_decoder_full.
- Walks a song ROM of {duration, note} entries and presents each 27-bit note word on `note`, holding it for a programmed number of tempo ticks.
- Handles start/stop/loop control and end-of-song detection.
- The decoder consumes `note` directly on the shared clk.

---
 rtl/note_sequencer.sv | 137 +++++++++++++
 tb/tb_note_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song ROM walker: fetches {duration, note} entries and holds each note word on `note`
// for duration tempo ticks, with start/stop/loop control and end-of-song detection.
module note_sequencer #(
  parameter int unsigned NOTE_W   = 27,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DUR_W+NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0]  TickLast = TickW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] AddrLast = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StPlay} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic               done_q, done_d;
  logic               song_end;

  logic [DUR_W-1:0]   rom_dur;
  logic [NOTE_W-1:0]  rom_note;

  assign rom_dur  = rom_data[DUR_W+NOTE_W-1:NOTE_W];
  assign rom_note = rom_data[NOTE_W-1:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    dur_d    = dur_q;
    tick_d   = tick_q;
    done_d   = 1'b0;
    song_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        note_d = '0;
        if (start && !stop) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        if (rom_dur == '0) begin
          song_end = 1'b1;
        end else begin
          note_d  = rom_note;
          dur_d   = rom_dur;
          tick_d  = '0;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          dur_d  = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            // Running off the top of the ROM counts as an end marker.
            if (addr_q == AddrLast) begin
              song_end = 1'b1;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = StFetch;
            end
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A marker at address 0 never loops, so an empty song cannot spin forever.
    if (song_end) begin
      if (loop_en && (addr_q != '0)) begin
        addr_d  = '0;
        state_d = StFetch;
      end else begin
        note_d  = '0;
        addr_d  = '0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end

    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      note_d  = '0;
      addr_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign note     = note_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a song-level schedule model predicts every output cycle,
// plus directed scenarios with hand-computed timing.
module tb_note_sequencer;

  localparam int unsigned NW   = 27;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 2;
  localparam int unsigned TICK = 4;
  localparam int          NENT = 4;

  localparam logic [NW-1:0] NA = 27'h35121;
  localparam logic [NW-1:0] NB = 27'h671511a;

  logic              clk = 1'b0;
  logic              rst, start, stop, loop_en;
  logic [AW-1:0]     rom_addr;
  logic [DW+NW-1:0]  rom_data;
  logic [NW-1:0]     note;
  logic              busy, done;

  logic [DW+NW-1:0]  rom [NENT];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [NW-1:0] note;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t q[$];
  exp_t exp_s = '0;

  logic [NW-1:0] cap_note [100];
  logic [NW-1:0] cap_mnote[100];
  logic [AW-1:0] cap_addr [100];
  logic          cap_done [100];
  logic          cap_mdone[100];
  logic          cap_busy [100];

  note_sequencer #(
    .NOTE_W  (NW),
    .DUR_W   (DW),
    .ADDR_W  (AW),
    .TICK_DIV(TICK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .note    (note),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Registered ROM read: one cycle of latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [NW-1:0] n, input int a, input logic b,
                               input logic d);
    exp_t e;
    e.note = n;
    e.addr = AW'(a);
    e.busy = b;
    e.done = d;
    q.push_back(e);
  endfunction

  // Expected output for every cycle after an accepted start, derived from the song rules.
  function automatic void plan();
    int            addr = 0;
    int            dur;
    logic [NW-1:0] nt = '0;
    q.delete();
    while (q.size() < 3000) begin
      push(nt, addr, 1'b1, 1'b0);  // fetch
      push(nt, addr, 1'b1, 1'b0);  // load
      dur = int'(rom[addr][DW+NW-1:NW]);
      if (dur != 0) begin
        nt = rom[addr][NW-1:0];
        for (int i = 0; i < dur * int'(TICK); i++) push(nt, addr, 1'b1, 1'b0);
        if (addr != NENT - 1) begin
          addr++;
          continue;
        end
      end
      if (loop_en && addr != 0) begin
        addr = 0;
      end else begin
        push('0, 0, 1'b0, 1'b1);
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_s <= '0;
    end else if (exp_s.busy && stop) begin
      q.delete();
      exp_s <= '0;
    end else if (!exp_s.busy && start && !stop) begin
      plan();
      exp_s <= q.pop_front();
    end else if (q.size() != 0) begin
      exp_s <= q.pop_front();
    end else begin
      exp_s <= '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("note", 32'(note), 32'(exp_s.note));
      check("rom_addr", 32'(rom_addr), 32'(exp_s.addr));
      check("busy", 32'(busy), 32'(exp_s.busy));
      check("done", 32'(done), 32'(exp_s.done));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 1; i <= n; i++) begin
      cap_note[i]  = note;
      cap_mnote[i] = exp_s.note;
      cap_addr[i]  = rom_addr;
      cap_done[i]  = done;
      cap_mdone[i] = exp_s.done;
      cap_busy[i]  = busy;
      @(negedge clk);
    end
  endtask

  function automatic int cnt_note(input logic [NW-1:0] v, input int n, input bit model);
    int c = 0;
    for (int i = 1; i <= n; i++) begin
      if ((model ? cap_mnote[i] : cap_note[i]) == v) c++;
    end
    return c;
  endfunction

  function automatic int cnt_done(input int n, input bit model);
    int c = 0;
    for (int i = 1; i <= n; i++) begin
      if (model ? cap_mdone[i] : cap_done[i]) c++;
    end
    return c;
  endfunction

  task automatic load_song1();
    rom[0] = {16'd3, NA};
    rom[1] = {16'd2, NB};
    rom[2] = {16'd0, 27'h0};
    rom[3] = {16'd0, 27'h0};
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    load_song1();
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain playback of the two-note song.
    pulse_start();
    capture(30);
    check("s1_first_note_idx2", 32'(cap_mnote[2]), 32'h0);
    check("s1_first_note_idx3", 32'(cap_mnote[3]), 32'(NA));
    check("s1_model_a_len", 32'(cnt_note(NA, 30, 1'b1)), 32'd14);
    check("s1_model_b_len", 32'(cnt_note(NB, 30, 1'b1)), 32'd10);
    check("s1_dut_a_len", 32'(cnt_note(NA, 30, 1'b0)), 32'd14);
    check("s1_dut_b_len", 32'(cnt_note(NB, 30, 1'b0)), 32'd10);
    check("s1_done_idx", 32'(cap_mdone[27]), 32'd1);
    check("s1_done_count", 32'(cnt_done(30, 1'b0)), 32'd1);
    check("s1_busy_before_end", 32'(cap_busy[26]), 32'd1);
    check("s1_busy_at_end", 32'(cap_busy[27]), 32'd0);

    // Looping: period is 14 + 12 cycles once the marker refetches address 0.
    loop_en = 1'b1;
    pulse_start();
    capture(90);
    check("loop_b_before_wrap", 32'(cap_mnote[28]), 32'(NB));
    check("loop_a_2nd", 32'(cap_mnote[29]), 32'(NA));
    check("loop_a_3rd", 32'(cap_mnote[55]), 32'(NA));
    check("loop_a_4th_dut", 32'(cap_note[81]), 32'(NA));
    check("loop_no_done", 32'(cnt_done(90, 1'b0)), 32'd0);
    pulse_stop();
    check("loop_stop_busy", 32'(busy), 32'd0);

    // Stop mid-play, then replay.
    loop_en = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_stop();
    check("stop_note", 32'(note), 32'h0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_addr", 32'(rom_addr), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    pulse_start();
    capture(5);
    check("replay_note", 32'(cap_note[3]), 32'(NA));
    repeat (30) @(negedge clk);

    // Empty song: marker at address 0 terminates even with loop_en set.
    rom[0] = {16'd0, 27'h1234};
    loop_en = 1'b1;
    pulse_start();
    capture(6);
    check("empty_done_idx3", 32'(cap_done[3]), 32'd1);
    check("empty_model_done", 32'(cap_mdone[3]), 32'd1);
    check("empty_done_count", 32'(cnt_done(6, 1'b0)), 32'd1);
    check("empty_note_silent", 32'(cnt_note('0, 6, 1'b0)), 32'd6);
    check("empty_idle", 32'(cap_busy[4]), 32'd0);

    // Reset mid-play, then simultaneous start/stop from idle.
    load_song1();
    loop_en = 1'b0;
    pulse_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_note", 32'(note), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    capture(5);
    check("rst_no_done", 32'(cnt_done(5, 1'b0)), 32'd0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("startstop_stays_idle", 32'(busy), 32'd0);

    // Full ROM with every entry duration 1: ends at the top address, no wrap.
    for (int i = 0; i < NENT; i++) rom[i] = {16'd1, NW'(27'h100 + i)};
    pulse_start();
    capture(30);
    check("full_n0_len", 32'(cnt_note(27'h100, 30, 1'b1)), 32'd6);
    check("full_n1_len", 32'(cnt_note(27'h101, 30, 1'b0)), 32'd6);
    check("full_n2_len", 32'(cnt_note(27'h102, 30, 1'b0)), 32'd6);
    check("full_n3_len", 32'(cnt_note(27'h103, 30, 1'b1)), 32'd4);
    check("full_addr_last", 32'(cap_addr[24]), 32'd3);
    check("full_done_idx", 32'(cap_mdone[25]), 32'd1);
    check("full_done_count", 32'(cnt_done(30, 1'b0)), 32'd1);

    // Randomized songs with stray start/stop/rst pulses.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NENT; i++) begin
        rom[i] = {DW'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3)),
                  NW'($urandom)};
      end
      loop_en = 1'($urandom_range(0, 1));
      pulse_start();
      for (int c = 0; c < int'($urandom_range(20, 150)); c++) begin
        start = ($urandom_range(0, 15) == 0);
        stop  = ($urandom_range(0, 63) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      start = 1'b0; rst = 1'b0;
      pulse_stop();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
